// File: rtl/mult_pkg.sv
// Shared constants, mode encoding and carry-save tree sizing helpers for the
// pipelined CSA multiplier.
package mult_pkg;

    localparam int unsigned MULT_LATENCY = 3;

    typedef enum logic {
        MODE_UNSIGNED = 1'b0,
        MODE_SIGNED   = 1'b1
    } mult_mode_e;

    // One 3:2 level turns every full group of three rows into two.
    function automatic int unsigned csa_rows_after(input int unsigned n);
        return 2 * (n / 3) + (n % 3);
    endfunction

    function automatic int unsigned csa_rows_at(input int unsigned n, input int unsigned levels);
        int unsigned r;
        r = n;
        for (int unsigned l = 0; l < levels; l++) r = csa_rows_after(r);
        return r;
    endfunction

    function automatic int unsigned csa_levels_to(input int unsigned n, input int unsigned target);
        int unsigned r;
        int unsigned lv;
        r  = n;
        lv = 0;
        for (int unsigned k = 0; k < 64; k++) begin
            if (r > target) begin
                r  = csa_rows_after(r);
                lv = lv + 1;
            end
        end
        return lv;
    endfunction

    function automatic int unsigned csa_levels(input int unsigned n);
        return csa_levels_to(n, 2);
    endfunction

endpackage

// File: rtl/carry_lookahead_adder.sv
// Generate/propagate adder; the carry out of the top bit is not kept.
module carry_lookahead_adder #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum
);
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] c;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        c = '0;
        for (int unsigned i = 0; i + 1 < WIDTH; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
    end

    assign sum = p ^ c;
endmodule

// File: rtl/carry_save_adder.sv
// 3:2 carry-save cell; carry is returned already shifted to its column weight.
module carry_save_adder #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry
);
    assign sum   = a ^ b ^ c;
    assign carry = ((a & b) | (a & c) | (b & c)) << 1;
endmodule

// File: rtl/csa_reduction_tree.sv
// Combinational chain of carry_save_adder levels reducing ROWS_IN rows to ROWS_OUT.
module csa_reduction_tree
    import mult_pkg::*;
#(
    parameter int unsigned ROWS_IN  = 17,
    parameter int unsigned ROWS_OUT = 2,
    parameter int unsigned W        = 32
) (
    input  logic [W-1:0] rows_in  [ROWS_IN],
    output logic [W-1:0] rows_out [ROWS_OUT]
);
    localparam int unsigned LEVELS = csa_levels_to(ROWS_IN, ROWS_OUT);

    logic [W-1:0] stage [LEVELS+1][ROWS_IN];

    for (genvar r = 0; r < ROWS_IN; r++) begin : g_in
        assign stage[0][r] = rows_in[r];
    end

    for (genvar l = 0; l < LEVELS; l++) begin : g_level
        localparam int unsigned N  = csa_rows_at(ROWS_IN, l);
        localparam int unsigned G  = N / 3;
        localparam int unsigned NN = csa_rows_at(ROWS_IN, l + 1);

        for (genvar g = 0; g < G; g++) begin : g_csa
            carry_save_adder #(.WIDTH(W)) u_csa (
                .a    (stage[l][3*g]),
                .b    (stage[l][3*g+1]),
                .c    (stage[l][3*g+2]),
                .sum  (stage[l+1][2*g]),
                .carry(stage[l+1][2*g+1])
            );
        end
        // Leftover rows of an incomplete group skip this level untouched.
        for (genvar k = 0; k < N % 3; k++) begin : g_pass
            assign stage[l+1][2*G+k] = stage[l][3*G+k];
        end
        for (genvar r = NN; r < ROWS_IN; r++) begin : g_zero
            assign stage[l+1][r] = '0;
        end
    end

    for (genvar r = 0; r < ROWS_OUT; r++) begin : g_out
        assign rows_out[r] = stage[LEVELS][r];
    end
endmodule

// File: rtl/pipelined_csa_multiplier.sv
// Three-stage valid/ready WIDTH x WIDTH carry-save multiplier, unsigned or Baugh-Wooley signed.
// Define APPROX_TRUNC_EN to drop the TRUNC_COLS least-significant partial-product columns.
module pipelined_csa_multiplier
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned TRUNC_COLS = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic                 signed_i,
    input  logic [WIDTH-1:0]     operand1_i,
    input  logic [WIDTH-1:0]     operand2_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [2*WIDTH-1:0]   product_o
);
    localparam int unsigned PW        = 2 * WIDTH;
    localparam int unsigned ROWS      = WIDTH + 1;
    localparam int unsigned LEVELS    = csa_levels(ROWS);
    localparam int unsigned S1_LEVELS = (LEVELS + 1) / 2;
    localparam int unsigned S1_ROWS   = csa_rows_at(ROWS, S1_LEVELS);

    if (WIDTH < 4 || WIDTH > 32 || TRUNC_COLS > WIDTH) begin : g_bad_params
        $error("pipelined_csa_multiplier: WIDTH must be 4..32 and TRUNC_COLS <= WIDTH");
    end

    mult_mode_e  mode;
    logic [PW-1:0] pp      [ROWS];
    logic [PW-1:0] s1_next [S1_ROWS];
    logic [PW-1:0] s1_rows [S1_ROWS];
    logic [PW-1:0] s2_next [2];
    logic [PW-1:0] s2_rows [2];
    logic [PW-1:0] sum_w;
    logic          s1_valid, s2_valid;
    logic          adv1, adv2, adv3;

    assign mode = signed_i ? MODE_SIGNED : MODE_UNSIGNED;

    // Row WIDTH carries the Baugh-Wooley constants (columns WIDTH and 2*WIDTH-1).
    always_comb begin : pp_gen
        logic pp_bit;
        pp_bit = 1'b0;
        for (int unsigned i = 0; i < ROWS; i++) pp[i] = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            for (int unsigned j = 0; j < WIDTH; j++) begin
                pp_bit = operand1_i[j] & operand2_i[i];
                if (mode == MODE_SIGNED && ((i == WIDTH - 1) != (j == WIDTH - 1))) pp_bit = ~pp_bit;
`ifdef APPROX_TRUNC_EN
                if (i + j < TRUNC_COLS) pp_bit = 1'b0;
`endif
                pp[i][i+j] = pp_bit;
            end
        end
        if (mode == MODE_SIGNED) begin
            pp[WIDTH][WIDTH] = 1'b1;
            pp[WIDTH][PW-1]  = 1'b1;
        end
    end

    csa_reduction_tree #(.ROWS_IN(ROWS), .ROWS_OUT(S1_ROWS), .W(PW)) u_tree_s1 (
        .rows_in (pp),
        .rows_out(s1_next)
    );

    csa_reduction_tree #(.ROWS_IN(S1_ROWS), .ROWS_OUT(2), .W(PW)) u_tree_s2 (
        .rows_in (s1_rows),
        .rows_out(s2_next)
    );

    carry_lookahead_adder #(.WIDTH(PW)) u_cla (
        .a  (s2_rows[0]),
        .b  (s2_rows[1]),
        .sum(sum_w)
    );

    // A stage may load when empty or when its occupant moves on, so bubbles collapse.
    assign adv3    = !valid_o || ready_i;
    assign adv2    = !s2_valid || adv3;
    assign adv1    = !s1_valid || adv2;
    assign ready_o = adv1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            valid_o   <= 1'b0;
            product_o <= '0;
        end else begin
            if (adv1) s1_valid <= valid_i;
            if (adv2) s2_valid <= s1_valid;
            if (adv3) valid_o  <= s2_valid;
            if (adv3 && s2_valid) product_o <= sum_w;
        end
    end

    always_ff @(posedge clk_i) begin
        if (adv1 && valid_i)  s1_rows <= s1_next;
        if (adv2 && s1_valid) s2_rows <= s2_next;
    end
endmodule
